hyper_ddr_rx_packer: RTL

Parametrised HyperBus read-data receiver. It sits between the DDR capture stage and the AXI read path. Each cycle it accepts at most one captured DDR sample (rising-edge and falling-edge byte lanes) and packs consecutive samples into wide words. It buffers those words in a small FIFO and releases them over a valid/ready handshake, counting a programmed burst length and flagging lost data.

---
 rtl/hyper_rx_pkg.sv | 18 +
 rtl/hyper_rx_fifo.sv | 73 +++++++
 rtl/hyper_ddr_rx_packer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hyper_rx_pkg.sv
// Shared types and helpers for the HyperBus read-data receiver.
//   rx_state_e : burst FSM states (IDLE, RECV, DRAIN)
//   pack_ratio : number of DDR samples packed into one output word
package hyper_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } rx_state_e;

  // Each DDR sample carries 2*dq_width bits (both RWDS edges).
  function automatic int unsigned pack_ratio(input int unsigned dq_width,
                                             input int unsigned data_width);
    return data_width / (2 * dq_width);
  endfunction

endpackage

// File: rtl/hyper_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for packed read words.
//   flush_i         : synchronous clear of all entries (wins over push/pop)
//   push_i, data_i  : write request; accepted when not full or when popping
//   pop_i           : advance the head; ignored when empty
//   data_o          : head word, 0 while empty
//   full_o, empty_o : occupancy flags
module hyper_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push-while-full is legal then.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hyper_ddr_rx_packer.sv
// HyperBus read-data receiver: packs DDR samples into wide words, buffers
// them in a small FIFO and counts a programmed burst length.
//   clear_i          : synchronous abort of burst, FIFO and overflow flag
//   start_i, len_i, swap_i : burst start (IDLE only), word count, byte order
//   sample_*         : one captured DDR sample per cycle, never stalled
//   data_o/valid_o/ready_i : output word handshake
//   busy_o, done_o, overflow_o : burst status; overflow_o is sticky
module hyper_ddr_rx_packer
  import hyper_rx_pkg::*;
#(
  parameter int unsigned DQ_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  swap_i,
  input  logic                  sample_valid_i,
  input  logic [DQ_WIDTH-1:0]   sample_pos_i,
  input  logic [DQ_WIDTH-1:0]   sample_neg_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam int unsigned R   = pack_ratio(DQ_WIDTH, DATA_WIDTH);
  localparam int unsigned HW  = 2 * DQ_WIDTH;
  localparam int unsigned PCW = (R > 1) ? $clog2(R) : 1;
  localparam logic [PCW-1:0] PCNT_LAST = PCW'(R - 1);

  rx_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PCW-1:0]        pcnt_q, pcnt_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic                  swap_q, swap_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [HW-1:0]         half;
  logic [DATA_WIDTH-1:0] word;
  logic                  sample_take, word_done;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

  assign sample_take = (state_q == RECV) && sample_valid_i;
  assign word_done   = sample_take && (pcnt_q == PCNT_LAST);
  assign fifo_pop    = !fifo_empty && ready_i;
  assign fifo_push   = word_done && !clear_i && (!fifo_full || fifo_pop);
  assign drop        = word_done && !clear_i && fifo_full && !fifo_pop;

  // The completed word is the pack register with the current sample merged
  // in, so the last sample reaches the FIFO on the edge that captures it.
  always_comb begin
    half = swap_q ? {sample_neg_i, sample_pos_i} : {sample_pos_i, sample_neg_i};
    word = pack_q;
    word[HW*int'(pcnt_q) +: HW] = half;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    pack_d  = pack_q;
    swap_d  = swap_q;
    ovf_d   = ovf_q | drop;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      pack_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              cnt_d   = len_i;
              pcnt_d  = '0;
              swap_d  = swap_i;
              state_d = RECV;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RECV: begin
          if (sample_take) begin
            pack_d = word;
            if (word_done) begin
              pcnt_d = '0;
              cnt_d  = cnt_q - 1'b1;
              if (cnt_q == LEN_WIDTH'(1)) state_d = DRAIN;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pack_q  <= '0;
      swap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pack_q  <= pack_d;
      swap_q  <= swap_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  hyper_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .push_i  (fifo_push),
    .data_i  (word),
    .pop_i   (fifo_pop),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_o    = !fifo_empty;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule
